// File: rtl/foc_cmd_apply.sv
// foc_cmd_apply: gates decoded host commands onto the FOC loop setpoints.
// Validates mode and sequence id, and forces a zero setpoint on command
// watchdog expiry or power-stage fault until the host sends an explicit idle.
module foc_cmd_apply #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000,
  parameter logic [7:0]  MAX_MODE       = 8'd4
) (
  input  logic        c,
  input  logic        rst_n,
  input  logic        cmd_rx,
  input  logic [7:0]  control_mode,
  input  logic [31:0] control_id,
  input  logic [31:0] target,
  input  logic [31:0] damping,
  input  logic        fault,
  output logic [7:0]  out_mode,
  output logic [31:0] out_target,
  output logic [31:0] out_damping,
  output logic        out_apply,
  output logic [1:0]  state,
  output logic [15:0] accept_cnt,
  output logic [15:0] reject_cnt
);

  localparam int unsigned MODE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  state_t              r_state,   w_state_nx;
  logic [MODE_W-1:0]   r_mode,    w_mode_nx;
  logic [WORD_W-1:0]   r_target,  w_target_nx;
  logic [WORD_W-1:0]   r_damping, w_damping_nx;
  logic                r_apply,   w_apply_nx;
  logic [CNT_W-1:0]    r_acc,     w_acc_nx;
  logic [CNT_W-1:0]    r_rej,     w_rej_nx;
  logic [WORD_W-1:0]   r_last_id, w_last_id_nx;
  logic                r_id_seen, w_id_seen_nx;
  logic [WORD_W-1:0]   r_wdog,    w_wdog_nx;

  logic                w_accept;
  logic                w_expire;
  logic [WORD_W:0]     w_wdog_inc;

  // Command acceptance: no fault, legal mode, fresh id, and only idle requests
  // while locked out in TIMEOUT/FAULT.
  assign w_accept = cmd_rx && !fault
                 && (control_mode <= MAX_MODE)
                 && (!r_id_seen || (control_id != r_last_id))
                 && ((r_state == ST_IDLE) || (r_state == ST_RUN) ||
                     (control_mode == MODE_W'(0)));

  // Watchdog expiry: count would reach the limit this clock and no command arrived.
  assign w_wdog_inc = {1'b0, r_wdog} + (WORD_W+1)'(1);
  assign w_expire   = (r_state == ST_RUN) && (TIMEOUT_CYCLES != WORD_W'(0)) && !cmd_rx
                   && (w_wdog_inc >= {1'b0, TIMEOUT_CYCLES});

  // State and output registers.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mode    <= '0;
      r_target  <= '0;
      r_damping <= '0;
      r_apply   <= 1'b0;
      r_acc     <= '0;
      r_rej     <= '0;
      r_last_id <= '0;
      r_id_seen <= 1'b0;
      r_wdog    <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_mode    <= w_mode_nx;
      r_target  <= w_target_nx;
      r_damping <= w_damping_nx;
      r_apply   <= w_apply_nx;
      r_acc     <= w_acc_nx;
      r_rej     <= w_rej_nx;
      r_last_id <= w_last_id_nx;
      r_id_seen <= w_id_seen_nx;
      r_wdog    <= w_wdog_nx;
    end
  end

  // Next-state, setpoint, counter and watchdog logic; fault beats accept beats expiry.
  always_comb begin
    w_state_nx   = r_state;
    w_mode_nx    = r_mode;
    w_target_nx  = r_target;
    w_damping_nx = r_damping;
    w_apply_nx   = 1'b0;
    w_acc_nx     = r_acc;
    w_rej_nx     = r_rej;
    w_last_id_nx = r_last_id;
    w_id_seen_nx = r_id_seen;
    w_wdog_nx    = r_wdog;

    if (w_accept) begin
      w_acc_nx     = r_acc + CNT_W'(1);
      w_last_id_nx = control_id;
      w_id_seen_nx = 1'b1;
    end else if (cmd_rx) begin
      w_rej_nx     = r_rej + CNT_W'(1);
    end

    if (fault) begin
      w_state_nx = ST_FAULT;
      if (r_state != ST_FAULT) begin
        w_mode_nx    = '0;
        w_target_nx  = '0;
        w_damping_nx = '0;
        w_apply_nx   = 1'b1;
      end
    end else if (w_accept) begin
      w_state_nx   = (control_mode != MODE_W'(0)) ? ST_RUN : ST_IDLE;
      w_mode_nx    = control_mode;
      w_target_nx  = target;
      w_damping_nx = damping;
      w_apply_nx   = 1'b1;
    end else if (w_expire) begin
      w_state_nx   = ST_TIMEOUT;
      w_mode_nx    = '0;
      w_target_nx  = '0;
      w_damping_nx = '0;
      w_apply_nx   = 1'b1;
    end

    if (w_accept || (w_state_nx != r_state)) begin
      w_wdog_nx = '0;
    end else if ((r_state == ST_RUN) && (r_wdog != '1)) begin
      w_wdog_nx = r_wdog + WORD_W'(1);
    end
  end

  assign out_mode    = r_mode;
  assign out_target  = r_target;
  assign out_damping = r_damping;
  assign out_apply   = r_apply;
  assign state       = r_state;
  assign accept_cnt  = r_acc;
  assign reject_cnt  = r_rej;

endmodule

// File: tb/tb_foc_cmd_apply.sv
// Bench for foc_cmd_apply: directed command sequences, a behavioural model
// compared every cycle, and literal spot checks that pin the model.
module tb_foc_cmd_apply;

  localparam int unsigned TO = 100;

  logic        c = 1'b0;
  logic        rst_n;
  logic        cmd_rx;
  logic [7:0]  control_mode;
  logic [31:0] control_id;
  logic [31:0] target;
  logic [31:0] damping;
  logic        fault;

  logic [7:0]  out_mode;
  logic [31:0] out_target, out_damping;
  logic        out_apply;
  logic [1:0]  state;
  logic [15:0] accept_cnt, reject_cnt;

  logic [7:0]  d2_mode;
  logic [31:0] d2_target, d2_damping;
  logic        d2_apply;
  logic [1:0]  d2_state;
  logic [15:0] d2_acc, d2_rej;

  foc_cmd_apply #(.TIMEOUT_CYCLES(32'(TO)), .MAX_MODE(8'd4)) dut (
    .c(c), .rst_n(rst_n), .cmd_rx(cmd_rx), .control_mode(control_mode),
    .control_id(control_id), .target(target), .damping(damping), .fault(fault),
    .out_mode(out_mode), .out_target(out_target), .out_damping(out_damping),
    .out_apply(out_apply), .state(state), .accept_cnt(accept_cnt),
    .reject_cnt(reject_cnt)
  );

  // Same stimulus with the watchdog disabled.
  foc_cmd_apply #(.TIMEOUT_CYCLES(32'd0), .MAX_MODE(8'd4)) dut_nowd (
    .c(c), .rst_n(rst_n), .cmd_rx(cmd_rx), .control_mode(control_mode),
    .control_id(control_id), .target(target), .damping(damping), .fault(fault),
    .out_mode(d2_mode), .out_target(d2_target), .out_damping(d2_damping),
    .out_apply(d2_apply), .state(d2_state), .accept_cnt(d2_acc),
    .reject_cnt(d2_rej)
  );

  always #5 c = ~c;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0 IDLE, 1 RUN, 2 TIMEOUT, 3 FAULT.
  int          m_state;
  logic [7:0]  m_mode;
  logic [31:0] m_target, m_damping, m_last;
  bit          m_seen, m_apply;
  logic [15:0] m_acc, m_rej;
  int          m_quiet;   // clocks spent in RUN since last accept / entry

  always @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_mode = 0; m_target = 0; m_damping = 0; m_last = 0;
      m_seen = 0; m_apply = 0; m_acc = 0; m_rej = 0; m_quiet = 0;
    end else begin
      bit legal;
      int prev;
      prev  = m_state;
      legal = cmd_rx && !fault && (control_mode <= 8'd4) &&
              (!m_seen || control_id != m_last) &&
              (m_state <= 1 || control_mode == 8'd0);
      m_apply = 0;
      if (cmd_rx) begin
        if (legal) m_acc = m_acc + 16'd1;
        else       m_rej = m_rej + 16'd1;
      end
      if (fault) begin
        if (m_state != 3) begin
          m_mode = 0; m_target = 0; m_damping = 0; m_apply = 1;
        end
        m_state = 3;
      end else if (legal) begin
        m_last = control_id; m_seen = 1;
        m_mode = control_mode; m_target = target; m_damping = damping;
        m_apply = 1;
        m_state = (control_mode != 0) ? 1 : 0;
      end else if (m_state == 1 && !cmd_rx && (m_quiet + 1) >= int'(TO)) begin
        m_state = 2; m_mode = 0; m_target = 0; m_damping = 0; m_apply = 1;
      end
      if (legal || m_state != prev) m_quiet = 0;
      else if (m_state == 1) m_quiet++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge c) begin
    chk("cmp_state",   32'(state),      32'(m_state));
    chk("cmp_mode",    32'(out_mode),   32'(m_mode));
    chk("cmp_target",  out_target,      m_target);
    chk("cmp_damping", out_damping,     m_damping);
    chk("cmp_apply",   32'(out_apply),  32'(m_apply));
    chk("cmp_acc",     32'(accept_cnt), 32'(m_acc));
    chk("cmp_rej",     32'(reject_cnt), 32'(m_rej));
  end

  task automatic send(input logic [7:0] m, input logic [31:0] id,
                      input logic [31:0] t, input logic [31:0] d);
    @(negedge c);
    cmd_rx = 1'b1; control_mode = m; control_id = id; target = t; damping = d;
    @(negedge c);
    cmd_rx = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge c);
  endtask

  initial begin
    rst_n = 1'b0; cmd_rx = 1'b0; control_mode = '0; control_id = '0;
    target = '0; damping = '0; fault = 1'b0;
    idle(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_mode",  32'(out_mode), 32'd0);
    chk("rst_apply", 32'(out_apply), 32'd0);
    chk("rst_acc",   32'(accept_cnt), 32'd0);
    rst_n = 1'b1;

    // 1: first command applied with one cycle latency
    send(8'd1, 32'd5, 32'h3F80_0000, 32'h0000_1234);
    chk("t1_mode",   32'(out_mode), 32'd1);
    chk("t1_target", out_target, 32'h3F80_0000);
    chk("t1_damp",   out_damping, 32'h0000_1234);
    chk("t1_apply",  32'(out_apply), 32'd1);
    chk("t1_state",  32'(state), 32'd1);
    chk("t1_acc",    32'(accept_cnt), 32'd1);
    idle(1);
    chk("t1_apply_once", 32'(out_apply), 32'd0);

    // 2: duplicate id, illegal modes, then rejected id reused
    send(8'd2, 32'd5, 32'h1, 32'h2);
    chk("t2_rej1", 32'(reject_cnt), 32'd1);
    chk("t2_hold", 32'(out_mode), 32'd1);
    send(8'd7, 32'd6, 32'h1, 32'h2);
    chk("t2_rej2", 32'(reject_cnt), 32'd2);
    send(8'd5, 32'd6, 32'h1, 32'h2);
    chk("t2_rej3", 32'(reject_cnt), 32'd3);
    send(8'd4, 32'd6, 32'hAAAA_5555, 32'h0F0F_0F0F);
    chk("t2_acc", 32'(accept_cnt), 32'd2);
    chk("t2_mode4", 32'(out_mode), 32'd4);

    // 3: watchdog expiry after TO quiet clocks
    idle(99);
    chk("t3_pre", 32'(state), 32'd1);
    idle(1);
    chk("t3_state", 32'(state), 32'd2);
    chk("t3_zero", out_target, 32'd0);
    chk("t3_apply", 32'(out_apply), 32'd1);
    chk("t3_nowd_run", 32'(d2_state), 32'd1);
    idle(1);
    chk("t3_apply_once", 32'(out_apply), 32'd0);
    send(8'd1, 32'd7, 32'h5, 32'h6);
    chk("t3_rej", 32'(reject_cnt), 32'd4);
    chk("t3_stay", 32'(state), 32'd2);
    send(8'd0, 32'd8, 32'h11, 32'h22);
    chk("t3_idle", 32'(state), 32'd0);
    chk("t3_tgt", out_target, 32'h11);

    // 4: command on the exact expiry clock keeps RUN and restarts the watchdog
    send(8'd1, 32'd9, 32'h7, 32'h8);
    idle(98);
    send(8'd4, 32'd10, 32'h9, 32'hA);
    chk("t4_run", 32'(state), 32'd1);
    chk("t4_acc", 32'(accept_cnt), 32'd5);
    idle(99);
    chk("t4_restart", 32'(state), 32'd1);
    idle(1);
    chk("t4_expire", 32'(state), 32'd2);
    send(8'd0, 32'd11, 32'h0, 32'h0);
    chk("t4_idle", 32'(state), 32'd0);

    // 5: fault lockout
    send(8'd1, 32'd12, 32'hC, 32'hD);
    @(negedge c);
    fault = 1'b1; cmd_rx = 1'b1; control_mode = 8'd1; control_id = 32'd13;
    @(negedge c);
    cmd_rx = 1'b0;
    chk("t5_state", 32'(state), 32'd3);
    chk("t5_zero", 32'(out_mode), 32'd0);
    chk("t5_apply", 32'(out_apply), 32'd1);
    chk("t5_rej", 32'(reject_cnt), 32'd5);
    send(8'd0, 32'd14, 32'h1, 32'h1);
    chk("t5_rej_hi", 32'(reject_cnt), 32'd6);
    chk("t5_hold", 32'(state), 32'd3);
    fault = 1'b0;
    idle(1);
    chk("t5_latched", 32'(state), 32'd3);
    send(8'd0, 32'd14, 32'h33, 32'h44);
    chk("t5_idle", 32'(state), 32'd0);
    chk("t5_acc", 32'(accept_cnt), 32'd8);
    send(8'd0, 32'd14, 32'h55, 32'h66);
    chk("t5_dup", 32'(reject_cnt), 32'd7);

    // 6: asynchronous reset during RUN with commands in flight
    send(8'd1, 32'd15, 32'hE, 32'hF);
    @(negedge c);
    cmd_rx = 1'b1; control_mode = 8'd2; control_id = 32'd16;
    @(posedge c);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_mode", 32'(out_mode), 32'd0);
    chk("t6_tgt", out_target, 32'd0);
    chk("t6_apply", 32'(out_apply), 32'd0);
    chk("t6_acc", 32'(accept_cnt), 32'd0);
    chk("t6_rej", 32'(reject_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge c);
      cmd_rx = ~cmd_rx; control_id = control_id + 32'd1;
    end
    @(negedge c);
    cmd_rx = 1'b0;
    rst_n = 1'b1;
    send(8'd1, 32'd5, 32'h3F80_0000, 32'h0);
    chk("t6_reaccept", 32'(accept_cnt), 32'd1);
    chk("t6_run", 32'(state), 32'd1);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
